// File: rtl/ltl_report_collector.sv
`default_nettype none
// ============================================================================
//  Module   : ltl_report_collector
//  Purpose  : Samples the report vector of an LTL automata cluster on every
//             symbol cycle, tags each non-zero vector with the index of the
//             symbol that produced it, buffers the pair in a small FIFO and
//             drains it through a valid/ready port. Reports that arrive while
//             the FIFO is full are dropped and counted.
//  Options  : `define LTL_REPORT_DEDUP_EN to suppress a push whose vector
//             equals the vector of the previous run=1 cycle. Only a change
//             of the vector is then recorded.
//  Ports    : clk, reset (async, active low)   - clock / reset
//             run                              - one symbol consumed per cycle
//             clear                            - sync clear of all state
//             report_vec[NUM_REPORTS]          - report STE outputs
//             out_valid / out_ready            - drain handshake
//             out_report, out_index            - head entry contents
//             count                            - FIFO occupancy
//             overflow, drop_cnt               - sticky drop flag, drop total
//  Revision : 1.0 - initial release
// ============================================================================
module ltl_report_collector #(
    parameter int NUM_REPORTS = 4,
    parameter int IDX_W       = 16,
    parameter int DEPTH       = 8,
    parameter int DROP_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     clear,
    input  logic [NUM_REPORTS-1:0]   report_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_REPORTS-1:0]   out_report,
    output logic [IDX_W-1:0]         out_index,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [NUM_REPORTS-1:0] r_mem_rep [DEPTH];
    logic [IDX_W-1:0]       r_mem_idx [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [IDX_W-1:0]       r_index;
    logic                   r_overflow;
    logic [DROP_W-1:0]      r_drop_cnt;
    logic [NUM_REPORTS-1:0] r_out_report;
    logic [IDX_W-1:0]       r_out_index;

    logic                   w_dup;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push_req;
    logic                   w_push_ok;
    logic                   w_drop;
    logic [c_PTR_W-1:0]     w_rd_ptr_next;
    logic [c_CNT_W-1:0]     w_count_next;

`ifdef LTL_REPORT_DEDUP_EN
    logic [NUM_REPORTS-1:0] r_prev_vec;

    // Vector seen on the last run=1 cycle; a held report STE keeps the
    // vector unchanged, so only its first cycle is recorded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_prev_vec <= '0;
        else if (clear)
            r_prev_vec <= '0;
        else if (run)
            r_prev_vec <= report_vec;
    end

    assign w_dup = (report_vec == r_prev_vec);
`else
    assign w_dup = 1'b0;
`endif

    assign out_valid  = (r_count != '0);
    assign w_full     = (r_count == c_CNT_W'(DEPTH));
    assign w_pop      = out_valid & out_ready;
    assign w_push_req = run & (|report_vec) & ~w_dup;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push_ok  = w_push_req & (~w_full | w_pop) & ~clear;
    assign w_drop     = w_push_req & w_full & ~w_pop & ~clear;

    assign w_rd_ptr_next = w_pop ? r_rd_ptr + c_PTR_W'(1) : r_rd_ptr;

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok && !w_pop)
            w_count_next = r_count + c_CNT_W'(1);
        else if (w_pop && !w_push_ok)
            w_count_next = r_count - c_CNT_W'(1);
    end

    // Storage array carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem_rep[r_wr_ptr] <= report_vec;
            r_mem_idx[r_wr_ptr] <= r_index;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_index      <= '0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
            r_out_report <= '0;
            r_out_index  <= '0;
        end else if (clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (run)
                r_index <= r_index + IDX_W'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1)
                    r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
            // Head register: reload whenever the FIFO will be non-empty,
            // otherwise keep the last value shown. When the new head is the
            // slot being written on this edge, take the incoming data since
            // the array write has not landed yet.
            if (w_count_next != '0) begin
                if (w_push_ok && (w_rd_ptr_next == r_wr_ptr)) begin
                    r_out_report <= report_vec;
                    r_out_index  <= r_index;
                end else begin
                    r_out_report <= r_mem_rep[w_rd_ptr_next];
                    r_out_index  <= r_mem_idx[w_rd_ptr_next];
                end
            end
        end
    end

    assign out_report = r_out_report;
    assign out_index  = r_out_index;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ltl_report_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ltl_report_collector
//  Purpose  : Self-checking bench for ltl_report_collector. A queue-based
//             reference model tracks the expected FIFO contents, symbol
//             index and drop accounting. A second instance with a 4-bit
//             index shares the inputs to exercise index wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ltl_report_collector;

    localparam int NR = 4;
    localparam int IW = 16;
    localparam int D  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic          clear;
    logic [NR-1:0] report_vec;
    logic          out_ready;

    logic          out_valid;
    logic [NR-1:0] out_report;
    logic [IW-1:0] out_index;
    logic [3:0]    count;
    logic          overflow;
    logic [DW-1:0] drop_cnt;

    logic          o4_valid;
    logic [NR-1:0] o4_report;
    logic [3:0]    o4_index;
    logic [3:0]    o4_count;
    logic          o4_overflow;
    logic [DW-1:0] o4_drop;

    ltl_report_collector #(.NUM_REPORTS(NR), .IDX_W(IW), .DEPTH(D), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .report_vec(report_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_report(out_report),
        .out_index(out_index), .count(count), .overflow(overflow), .drop_cnt(drop_cnt));

    ltl_report_collector #(.NUM_REPORTS(NR), .IDX_W(4), .DEPTH(D), .DROP_W(DW)) dut4 (
        .clk(clk), .reset(reset), .run(run), .clear(clear), .report_vec(report_vec),
        .out_valid(o4_valid), .out_ready(out_ready), .out_report(o4_report),
        .out_index(o4_index), .count(o4_count), .overflow(o4_overflow), .drop_cnt(o4_drop));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [NR-1:0] rep;
        logic [IW-1:0] idx;
    } ent_t;

    ent_t          q[$];
    logic [IW-1:0] m_idx;
    logic          m_ovf;
    int            m_drop;
    logic [NR-1:0] m_out_rep;
    logic [IW-1:0] m_out_idx;
`ifdef LTL_REPORT_DEDUP_EN
    logic [NR-1:0] m_prev;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic model_reset();
        q.delete();
        m_idx     = '0;
        m_ovf     = 1'b0;
        m_drop    = 0;
        m_out_rep = '0;
        m_out_idx = '0;
`ifdef LTL_REPORT_DEDUP_EN
        m_prev    = '0;
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then wait for the edge
    // and settle 1 time unit past it.
    task automatic step(input logic r, input logic [NR-1:0] v, input logic rdy, input logic clr);
        bit pop, push;
        run = r; report_vec = v; out_ready = rdy; clear = clr;
        if (clr) begin
            q.delete();
            m_idx  = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
`ifdef LTL_REPORT_DEDUP_EN
            m_prev = '0;
`endif
        end else begin
            pop  = (q.size() != 0) && rdy;
            push = r && (v != '0);
`ifdef LTL_REPORT_DEDUP_EN
            if (r && v == m_prev) push = 1'b0;
            if (r) m_prev = v;
`endif
            if (push && q.size() == D && !pop) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
                push = 1'b0;
            end
            if (pop) void'(q.pop_front());
            if (push) q.push_back('{rep: v, idx: m_idx});
            if (r) m_idx++;
        end
        if (q.size() != 0) begin
            m_out_rep = q[0].rep;
            m_out_idx = q[0].idx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; run = 1'b0; clear = 1'b0; out_ready = 1'b0; report_vec = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Random non-zero vector different from 'last'.
    function automatic logic [NR-1:0] new_vec(input logic [NR-1:0] last);
        logic [NR-1:0] v;
        v = NR'($urandom_range(1, 15));
        if (v == last) v = (v == 4'd15) ? 4'd1 : v + 4'd1;
        return v;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [NR-1:0] v;
        apply_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_report !== '0) begin n_bad++; $display("FAIL reset_report: got %0h want 0", out_report); end
        n_cmp++; if (out_index !== '0) begin n_bad++; $display("FAIL reset_index: got %0h want 0", out_index); end
        n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_bad++; $display("FAIL reset_drop: got ovf=%0b drop=%0d want 0/0", overflow, drop_cnt); end
        v = '0;
        for (int i = 0; i < 3; i++) begin v = new_vec(v); step(1'b1, v, 1'b0, 1'b0); end
        // Asynchronous assertion mid-cycle must take effect without a clock edge.
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_async: got count=%0d valid=%0b want 0/0", count, out_valid); end
        n_cmp++; if (out_index !== '0 || out_report !== '0) begin n_bad++; $display("FAIL reset_async_head: got idx=%0h rep=%0h want 0/0", out_index, out_report); end
        @(posedge clk); #1;
        apply_reset();
    endtask

    task automatic test_first_report();
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, '0, 1'b1, 1'b0);
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %0b want 1", out_valid); end
        n_cmp++; if (out_report !== 4'b0010) begin n_bad++; $display("FAIL first_report: got %0b want 0010", out_report); end
        n_cmp++; if (out_index !== 16'd5) begin n_bad++; $display("FAIL first_index: got %0d want 5", out_index); end
        step(1'b1, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL first_drain: got valid %0b want 0", out_valid); end
        n_cmp++; if (out_index !== 16'd5) begin n_bad++; $display("FAIL empty_hold: got idx %0d want 5", out_index); end
    endtask

    task automatic test_overflow();
        int base, drained;
        apply_reset();
        base = $urandom_range(0, 14);
        for (int i = 0; i < 9; i++) step(1'b1, NR'(((base + i) % 15) + 1), 1'b0, 1'b0);
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL ovf_count: got %0d want 8", count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        n_cmp++; if (drop_cnt !== 8'd1) begin n_bad++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt); end
        drained = 0;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_report !== q[0].rep || out_index !== q[0].idx) begin
                n_bad++;
                $display("FAIL ovf_drain: got v=%0b rep=%0h idx=%0d want 1/%0h/%0d", out_valid, out_report, out_index, q[0].rep, q[0].idx);
            end
            step(1'b0, '0, 1'b1, 1'b0);
            drained++;
        end
        n_cmp++; if (drained !== 8 || out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %0d entries valid=%0b want 8/0", drained, out_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [NR-1:0] v;
        logic [IW-1:0] pushed_idx, last_idx;
        logic [NR-1:0] pushed_rep, last_rep;
        int drop_before;
        v = '0;
        for (int i = 0; i < D; i++) begin v = new_vec(v); step(1'b1, v, 1'b0, 1'b0); end
        drop_before = m_drop;
        pushed_idx  = m_idx;
        pushed_rep  = new_vec(v);
        step(1'b1, pushed_rep, 1'b1, 1'b0);
        n_cmp++; if (count !== 4'd8) begin n_bad++; $display("FAIL fpp_count: got %0d want 8", count); end
        n_cmp++; if (int'(drop_cnt) !== drop_before) begin n_bad++; $display("FAIL fpp_drop: got %0d want %0d", drop_cnt, drop_before); end
        last_idx = '0; last_rep = '0;
        for (int c = 0; c < 20 && out_valid === 1'b1; c++) begin
            last_idx = out_index; last_rep = out_report;
            step(1'b0, '0, 1'b1, 1'b0);
        end
        n_cmp++; if (last_idx !== pushed_idx || last_rep !== pushed_rep) begin n_bad++; $display("FAIL fpp_last: got idx=%0d rep=%0h want %0d/%0h", last_idx, last_rep, pushed_idx, pushed_rep); end
    endtask

    task automatic test_clear();
        logic [NR-1:0] v;
        v = '0;
        for (int i = 0; i < 3; i++) begin v = new_vec(v); step(1'b1, v, 1'b0, 1'b0); end
        n_cmp++; if (count !== 4'd3) begin n_bad++; $display("FAIL clr_fill: got %0d want 3", count); end
        step(1'b1, new_vec(v), 1'b1, 1'b1);
        n_cmp++; if (count !== '0 || out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_empty: got count=%0d valid=%0b want 0/0", count, out_valid); end
        n_cmp++; if (overflow !== 1'b0 || drop_cnt !== '0) begin n_bad++; $display("FAIL clr_ovf: got ovf=%0b drop=%0d want 0/0", overflow, drop_cnt); end
        step(1'b1, new_vec('0), 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_index !== '0) begin n_bad++; $display("FAIL clr_index: got valid=%0b idx=%0d want 1/0", out_valid, out_index); end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 20; i++) step(1'b1, (i == 17) ? new_vec('0) : '0, 1'b0, 1'b0);
        n_cmp++; if (o4_valid !== 1'b1 || o4_index !== 4'd1) begin n_bad++; $display("FAIL wrap_idx4: got valid=%0b idx=%0d want 1/1", o4_valid, o4_index); end
        n_cmp++; if (out_index !== 16'd17) begin n_bad++; $display("FAIL wrap_idx16: got %0d want 17", out_index); end
    endtask

    task automatic test_dedup();
        int want;
`ifdef LTL_REPORT_DEDUP_EN
        want = 2;
`else
        want = 5;
`endif
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1000, 1'b0, 1'b0);
        step(1'b1, 4'b0100, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (int'(count) !== want) begin n_bad++; $display("FAIL dedup_count: got %0d want %0d", count, want); end
        n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL dedup_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_saturation();
        logic [NR-1:0] v;
        apply_reset();
        v = '0;
        for (int i = 0; i < 270; i++) begin v = new_vec(v); step(1'b1, v, 1'b0, 1'b0); end
        n_cmp++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin n_bad++; $display("FAIL sat_drop: got drop=%0d ovf=%0b want 255/1", drop_cnt, overflow); end
    endtask

    task automatic test_random();
        logic [NR-1:0] v;
        logic r, rdy, clr;
        apply_reset();
        v = '0;
        for (int i = 0; i < 600; i++) begin
            r   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       v = '0;
                1:       v = v;
                default: v = NR'($urandom_range(1, 15));
            endcase
            // Alternate fill-heavy and drain-heavy phases to reach full and empty.
            rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 149) == 0);
            step(r, v, rdy, clr);
            n_cmp++; if (out_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, out_valid, q.size() != 0); end
            n_cmp++; if (int'(count) !== q.size()) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, q.size()); end
            n_cmp++; if (out_report !== m_out_rep || out_index !== m_out_idx) begin n_bad++; $display("FAIL rnd_head@%0d: got %0h/%0d want %0h/%0d", i, out_report, out_index, m_out_rep, m_out_idx); end
            n_cmp++; if (overflow !== m_ovf || int'(drop_cnt) !== m_drop) begin n_bad++; $display("FAIL rnd_drop@%0d: got %0b/%0d want %0b/%0d", i, overflow, drop_cnt, m_ovf, m_drop); end
        end
    endtask

    initial begin
        reset = 1'b0; run = 1'b0; clear = 1'b0; out_ready = 1'b0; report_vec = '0;
        model_reset();
        test_reset();
        test_first_report();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_wrap();
        test_dedup();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
